// File: rtl/sr_cmd_if.sv
// sr_cmd_if: command handshake between a controller (master) and an SR
// flip-flop driver (slave).
//   req_valid  master -> slave  command present
//   req_set    master -> slave  1 = set, 0 = reset
//   req_hold   master -> slave  pulse width in cycles (0 means 1)
//   req_ready  slave -> master  slave can accept a command this cycle
// Handshake: a command transfers on the rising clock edge where
// req_valid && req_ready. The master holds req_valid/req_set/req_hold
// stable until that edge. The slave raises req_ready only when idle and
// ignores every request field while req_ready is low.
interface sr_cmd_if #(
  parameter int HOLD_W = 4
) ();
  logic              req_valid;
  logic              req_set;
  logic [HOLD_W-1:0] req_hold;
  logic              req_ready;

  modport master (output req_valid, output req_set, output req_hold, input req_ready);
  modport slave  (input req_valid, input req_set, input req_hold, output req_ready);
endinterface

// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver: accepts set/reset commands and drives registered,
// mutually exclusive s/r pulses of programmable width into an SR flip-flop.
// Each pulse is followed by an idle gap. The block keeps a shadow copy of
// the flip-flop state, can drop commands that would not change it, and
// counts the pulses it issues.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   cmd          sr_cmd_if slave: req_valid/req_set/req_hold in, req_ready out
//   s, r         registered set/reset lines (never both high)
//   q_shadow     expected flip-flop state (0 after reset)
//   done         one-cycle pulse per completed or skipped command
//   busy         high while a pulse or its gap is in progress
//   pulse_count  pulses issued, wraps modulo 2^CNT_W
//   state_dbg    current FSM state (0 = IDLE, 1 = PULSE, 2 = GAP)
// Timing: the accept edge raises the active line. The line stays high for
// H = max(req_hold,1) cycles. Then s=r=0 for GAP_CYCLES cycles. The block
// is therefore not ready for H+GAP_CYCLES cycles after an accept.
module sr_cmd_driver #(
  parameter int HOLD_W         = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int SKIP_REDUNDANT = 1,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  sr_cmd_if.slave          cmd,
  output logic             s,
  output logic             r,
  output logic             q_shadow,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_count,
  output logic [1:0]       state_dbg
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               s_n, r_n, q_n, done_n;
  logic [CNT_W-1:0]   cnt_n;

  logic               accept;
  logic               redundant;
  logic [HOLD_W-1:0]  hold_eff;

  assign cmd.req_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

  assign accept    = cmd.req_valid && (state == ST_IDLE);
  assign redundant = (SKIP_REDUNDANT != 0) && (cmd.req_set == q_shadow);
  // A width of 0 means one cycle, so the down-counter never starts at 0.
  assign hold_eff  = (cmd.req_hold == '0) ? HOLD_W'(1) : cmd.req_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      s           <= 1'b0;
      r           <= 1'b0;
      q_shadow    <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_cnt_n;
      gap_cnt     <= gap_cnt_n;
      s           <= s_n;
      r           <= r_n;
      q_shadow    <= q_n;
      done        <= done_n;
      pulse_count <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    gap_cnt_n  = gap_cnt;
    s_n        = s;
    r_n        = r;
    q_n        = q_shadow;
    done_n     = 1'b0;
    cnt_n      = pulse_count;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (redundant) begin
            // The flip-flop already holds this value: acknowledge without a pulse.
            done_n = 1'b1;
          end else begin
            // s and r come from one bit and its complement, so both are never high.
            s_n        = cmd.req_set;
            r_n        = ~cmd.req_set;
            q_n        = cmd.req_set;
            cnt_n      = pulse_count + CNT_W'(1);
            hold_cnt_n = hold_eff;
            state_n    = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        if (hold_cnt == HOLD_W'(1)) begin
          s_n    = 1'b0;
          r_n    = 1'b0;
          done_n = 1'b1;
          if (GAP_CYCLES > 0) begin
            gap_cnt_n = GAP_LOAD;
            state_n   = ST_GAP;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          hold_cnt_n = hold_cnt - HOLD_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_n = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        s_n     = 1'b0;
        r_n     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Testbench for sr_cmd_driver.
// Instance 0 uses GAP_CYCLES=2 and instance 1 uses GAP_CYCLES=0. Both
// instances use SKIP_REDUNDANT=1, HOLD_W=4 and CNT_W=8.
// The reference model works in absolute edge numbers. Each accepted pulse
// records a start edge, an end edge and the first edge at which the next
// command can be accepted. Expected outputs after every edge are derived
// from those numbers.
module tb_sr_cmd_driver;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_cmd_if #(.HOLD_W(4)) if0 ();
  sr_cmd_if #(.HOLD_W(4)) if1 ();

  logic       s0, r0, q0, done0, busy0;
  logic       s1, r1, q1, done1, busy1;
  logic [7:0] cnt0, cnt1;
  logic [1:0] st0, st1;

  sr_cmd_driver #(.HOLD_W(4), .GAP_CYCLES(2), .SKIP_REDUNDANT(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .cmd(if0), .s(s0), .r(r0), .q_shadow(q0),
    .done(done0), .busy(busy0), .pulse_count(cnt0), .state_dbg(st0)
  );

  sr_cmd_driver #(.HOLD_W(4), .GAP_CYCLES(0), .SKIP_REDUNDANT(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .cmd(if1), .s(s1), .r(r1), .q_shadow(q1),
    .done(done1), .busy(busy1), .pulse_count(cnt1), .state_dbg(st1)
  );

  // Scoreboard counters and the checking task.
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, one entry per instance.
  int gap_of[2] = '{2, 0};
  int t;
  int free_at[2], p_start[2], p_end[2], done_at[2], n_acc[2];
  bit line_set[2], mq[2];
  logic [7:0] mcnt[2];

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      free_at[i]  = 0;
      p_start[i]  = 0;
      p_end[i]    = 0;
      done_at[i]  = -1;
      n_acc[i]    = 0;
      line_set[i] = 1'b0;
      mq[i]       = 1'b0;
      mcnt[i]     = 8'd0;
    end
  endfunction

  function automatic void m_step(input int i, input logic v, input logic set, input logic [3:0] hold);
    int h;
    if (v && t >= free_at[i]) begin
      if (set == mq[i]) begin
        // The command matches the shadow state, so it is skipped and acknowledged.
        done_at[i] = t;
        free_at[i] = t + 1;
      end else begin
        h = (hold == 0) ? 1 : int'(hold);
        line_set[i] = set;
        p_start[i]  = t;
        p_end[i]    = t + h;
        done_at[i]  = t + h;
        free_at[i]  = t + h + gap_of[i] + 1;
        mq[i]       = set;
        mcnt[i]     = mcnt[i] + 8'd1;
        n_acc[i]++;
      end
    end
  endfunction

  task automatic compare_inst(input int i, input logic s_v, input logic r_v, input logic q_v,
                              input logic done_v, input logic rdy_v, input logic busy_v,
                              input logic [7:0] cnt_v);
    bit act, rdy;
    act = (t >= p_start[i]) && (t < p_end[i]);
    rdy = (t + 1 >= free_at[i]);
    check_eq($sformatf("i%0d_s", i),     32'(s_v),    32'(act && line_set[i]));
    check_eq($sformatf("i%0d_r", i),     32'(r_v),    32'(act && !line_set[i]));
    check_eq($sformatf("i%0d_s_and_r", i), 32'(s_v && r_v), 32'(0));
    check_eq($sformatf("i%0d_q", i),     32'(q_v),    32'(mq[i]));
    check_eq($sformatf("i%0d_done", i),  32'(done_v), 32'(t == done_at[i]));
    check_eq($sformatf("i%0d_ready", i), 32'(rdy_v),  32'(rdy));
    check_eq($sformatf("i%0d_busy", i),  32'(busy_v), 32'(!rdy));
    check_eq($sformatf("i%0d_count", i), 32'(cnt_v),  32'(mcnt[i]));
  endtask

  // Monitor: feed the model the inputs present at each edge, then compare.
  always @(posedge clk) begin
    if (!rst) begin
      m_step(0, if0.req_valid, if0.req_set, if0.req_hold);
      m_step(1, if1.req_valid, if1.req_set, if1.req_hold);
      #1;
      compare_inst(0, s0, r0, q0, done0, if0.req_ready, busy0, cnt0);
      compare_inst(1, s1, r1, q1, done1, if1.req_ready, busy1, cnt1);
      t++;
    end
  end

  // Driver tasks. They drive the inputs of one instance in the current cycle.
  task automatic set_in(input int i, input bit v, input bit set, input logic [3:0] hold);
    if (i == 0) begin
      if0.req_valid = v; if0.req_set = set; if0.req_hold = hold;
    end else begin
      if1.req_valid = v; if1.req_set = set; if1.req_hold = hold;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      set_in(0, 1'b0, 1'b0, 4'd0);
      set_in(1, 1'b0, 1'b0, 4'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    t = 0;
    m_reset();
    set_in(0, 1'b0, 1'b0, 4'd0);
    set_in(1, 1'b0, 1'b0, 4'd0);
    #1;
    check_eq("rst_s",     32'(s0),    32'(0));
    check_eq("rst_r",     32'(r0),    32'(0));
    check_eq("rst_q",     32'(q0),    32'(0));
    check_eq("rst_done",  32'(done0), 32'(0));
    check_eq("rst_busy",  32'(busy0), 32'(0));
    check_eq("rst_count", 32'(cnt0),  32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Test 1: set with hold=3 on the GAP_CYCLES=2 instance.
    @(negedge clk); set_in(0, 1'b1, 1'b1, 4'd3);
    idle_cycles(8);
    check_eq("t1_count", 32'(cnt0), 32'(1));
    check_eq("t1_q",     32'(q0),   32'(1));

    // Test 2: a redundant set, then a reset with hold=0.
    @(negedge clk); set_in(0, 1'b1, 1'b1, 4'd2);
    idle_cycles(2);
    check_eq("t2_count_skip", 32'(cnt0), 32'(1));
    @(negedge clk); set_in(0, 1'b1, 1'b0, 4'd0);
    idle_cycles(5);
    check_eq("t2_q", 32'(q0), 32'(0));

    // Test 3: req_valid held high with alternating set/reset commands and hold=2.
    for (int k = 0; k < 24; k++) begin
      @(negedge clk); set_in(0, 1'b1, !mq[0], 4'd2);
    end
    idle_cycles(6);

    // Test 4: reset one cycle into a set pulse with hold=5.
    do_reset();
    @(negedge clk); set_in(0, 1'b1, 1'b1, 4'd5);
    @(negedge clk); set_in(0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    m_reset();
    #1;
    check_eq("t4_s_drop", 32'(s0),    32'(0));
    check_eq("t4_r_low",  32'(r0),    32'(0));
    check_eq("t4_q",      32'(q0),    32'(0));
    check_eq("t4_done",   32'(done0), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t4_ready", 32'(if0.req_ready), 32'(1));
    idle_cycles(8);

    // Test 5: 256 non-redundant commands on the GAP_CYCLES=0 instance.
    do_reset();
    begin
      int guard;
      guard = 0;
      while (n_acc[1] < 256 && guard < 3000) begin
        @(negedge clk); set_in(1, 1'b1, !mq[1], 4'd0);
        guard++;
      end
      set_in(1, 1'b0, 1'b0, 4'd0);
      check_eq("t5_bound", 32'(n_acc[1] >= 256), 32'(1));
    end
    idle_cycles(3);
    check_eq("t5_count_wrap", 32'(cnt1), 32'(0));

    // Test 6: hold=15 on the GAP_CYCLES=0 instance.
    @(negedge clk); set_in(1, 1'b1, !mq[1], 4'd15);
    idle_cycles(20);

    // Randomized traffic on both instances.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        set_in(i, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4)));
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
      end
    end
    idle_cycles(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
